alu_driver: RTL and testbench
=============================

Name: alu_driver

Overview:
- Sequencing stage directly upstream of the team's 16-op, 8-bit ALU.
- Accepts one operation per valid/ready handshake and registers the operands.
- Drives the ALU operand, command and output-enable inputs in a fixed LOAD→ISSUE order, captures the 16-bit ALU result, and returns it on a valid/ready result channel.
- Intercepts divide-by-zero and never issues it to the ALU; counts completed operations.

Parameters:
SETTLE_CYCLES, 1, cycles command_in/oe held before result capture (legal 1..15)
PARK_CMD, 4'b1111, command_in value driven whenever no operation is in ISSUE
DIV_CMD, 4'b0101, opcode treated as divide for the zero check

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  operation request
cmd_ready  output  1  block can accept an operation (high only in IDLE)
cmd_a  input  8  operand A
cmd_b  input  8  operand B
cmd_op  input  4  ALU opcode
a_in  output  8  to ALU operand A (registered)
b_in  output  8  to ALU operand B (registered)
command_in  output  4  to ALU command (registered)
oe  output  1  to ALU output enable (registered)
d_out  input  16  from ALU result; may be Z when oe=0
res_valid  output  1  result available
res_ready  input  1  consumer takes result
res_data  output  16  captured result
div_zero  output  1  qualifies res_data; divide by zero was intercepted
op_count  output  8  completed-operation count, wraps 255→0

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE.
  - a_in, b_in, res_data = 0; command_in = PARK_CMD; oe, res_valid, div_zero = 0; op_count = 0.
  - Any in-flight operation is dropped.
- Registered outputs: every output is a flop except cmd_ready, which decodes state only (no path from cmd_valid).
- States: IDLE, LOAD, ISSUE, HOLD.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: a_in←cmd_a, b_in←cmd_b, opcode latched internally.
  - If cmd_op==DIV_CMD and cmd_b==0: res_data←16'hFFFF, div_zero←1, res_valid←1, go HOLD. oe is never asserted.
  - Otherwise go LOAD.
- LOAD:
  - One cycle; command_in stays PARK_CMD, oe=0.
  - At the edge: command_in←latched op, oe←1, settle counter←SETTLE_CYCLES-1, go ISSUE.
- ISSUE:
  - Operands, command_in and oe are stable.
  - Counter decrements each edge.
  - On the edge where counter==0: res_data←d_out, div_zero←0, res_valid←1, oe←0, command_in←PARK_CMD, go HOLD.
- HOLD:
  - res_valid=1; res_data and div_zero are stable.
  - cmd_ready=0; cmd_valid is ignored.
  - On res_ready: res_valid←0, op_count←op_count+1 (modulo 256), go IDLE.
  - res_ready outside HOLD is ignored.
- Latency, counted in edges from the accept edge:
  - Normal op: res_valid rises SETTLE_CYCLES+1 edges after accept.
  - Divide-by-zero: res_valid rises 1 edge after accept.
- Throughput: at best one operation per SETTLE_CYCLES+3 cycles (accept cycle, LOAD, ISSUE, one HOLD cycle with res_ready).
- Z handling: d_out is sampled only while oe=1, so a Z/X value never reaches res_data.
- Width: res_data takes all 16 bits of d_out verbatim; no truncation or extension.

Test Plan:
1. ADD, a=8'hF0, b=8'h20, op=0, SETTLE=1, res_ready held 1 → res_valid 2 edges after accept, res_data=16'h0110, div_zero=0, op_count=1; oe high for exactly 1 cycle.
2. DIV, a=8'h64, b=0 → res_valid 1 edge after accept, res_data=16'hFFFF, div_zero=1, oe never high.
3. MUL, a=8'h0F, b=8'h0F, res_ready held 0 for 5 cycles → res_valid/res_data=16'h00E1 stable for all 5 cycles, cmd_ready=0, and a second cmd_valid is not accepted; completes when res_ready=1.
4. Back-to-back SUB (a=5, b=3) then SUB (a=9, b=4) → results 16'h0002 then 16'h0005; command_in returns to 4'b1111 between the two operations.
5. rst_n pulsed low during ISSUE → outputs asynchronously take reset values (oe=0, res_valid=0, op_count=0); the next command completes normally.
6. 256 completed operations → op_count wraps to 0; with SETTLE_CYCLES=4, oe high for 4 cycles and latency is 5 edges.

Source files
------------

// File: rtl/alu_driver.sv
// Sequencing stage in front of the 8-bit, 16-op ALU. It takes one operation per
// handshake, drives the ALU in LOAD then ISSUE order, and returns the 16-bit result.
module alu_driver #(
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [3:0]  PARK_CMD      = 4'b1111,
  parameter logic [3:0]  DIV_CMD       = 4'b0101
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [3:0]  cmd_op,
  output logic [7:0]  a_in,
  output logic [7:0]  b_in,
  output logic [3:0]  command_in,
  output logic        oe,
  input  logic [15:0] d_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        div_zero,
  output logic [7:0]  op_count
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; cmd_ready depends on state only, and res_valid holds until res_ready.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ISSUE = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [3:0]  op_q, op_d;
  logic [3:0]  command_q, command_d;
  logic        oe_q, oe_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        res_valid_q, res_valid_d;
  logic [15:0] res_data_q, res_data_d;
  logic        div_zero_q, div_zero_d;
  logic [7:0]  op_count_q, op_count_d;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    command_d   = command_q;
    oe_d        = oe_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    div_zero_d  = div_zero_q;
    op_count_d  = op_count_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          a_d  = cmd_a;
          b_d  = cmd_b;
          op_d = cmd_op;
          // Divide by zero never reaches the ALU; the result is synthesised here.
          if (cmd_op == DIV_CMD && cmd_b == 8'd0) begin
            res_data_d  = 16'hFFFF;
            div_zero_d  = 1'b1;
            res_valid_d = 1'b1;
            state_d     = S_HOLD;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        command_d = op_q;
        oe_d      = 1'b1;
        cnt_d     = SETTLE_LOAD;
        state_d   = S_ISSUE;
      end
      S_ISSUE: begin
        if (cnt_q == 4'd0) begin
          // d_out is only sampled here, while oe is still high.
          res_data_d  = d_out;
          div_zero_d  = 1'b0;
          res_valid_d = 1'b1;
          oe_d        = 1'b0;
          command_d   = PARK_CMD;
          state_d     = S_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          op_count_d  = op_count_q + 8'd1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= 8'd0;
      b_q         <= 8'd0;
      op_q        <= 4'd0;
      command_q   <= PARK_CMD;
      oe_q        <= 1'b0;
      cnt_q       <= 4'd0;
      res_valid_q <= 1'b0;
      res_data_q  <= 16'd0;
      div_zero_q  <= 1'b0;
      op_count_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      command_q   <= command_d;
      oe_q        <= oe_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      div_zero_q  <= div_zero_d;
      op_count_q  <= op_count_d;
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign a_in       = a_q;
  assign b_in       = b_q;
  assign command_in = command_q;
  assign oe         = oe_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign div_zero   = div_zero_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_driver.sv
// Bench for alu_driver: lane 0 runs SETTLE_CYCLES=1, lane 1 runs SETTLE_CYCLES=4,
// each against a stub ALU and an edge-counting reference model.
module tb_alu_driver;

  localparam logic [3:0] PARK  = 4'b1111;
  localparam logic [3:0] DIVOP = 4'b0101;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        cmd_valid  [2];
  logic        cmd_ready  [2];
  logic [7:0]  cmd_a      [2];
  logic [7:0]  cmd_b      [2];
  logic [3:0]  cmd_op     [2];
  logic [7:0]  a_in       [2];
  logic [7:0]  b_in       [2];
  logic [3:0]  command_in [2];
  logic        oe         [2];
  logic [15:0] d_out      [2];
  logic        res_valid  [2];
  logic        res_ready  [2];
  logic [15:0] res_data   [2];
  logic        div_zero   [2];
  logic [7:0]  op_count   [2];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] op);
    logic [15:0] r;
    case (op)
      4'd0: r = {8'h00, a} + {8'h00, b};
      4'd1: r = {8'h00, a} - {8'h00, b};
      4'd2: r = {8'h00, a} * {8'h00, b};
      4'd3: r = {8'h00, a & b};
      4'd4: r = {8'h00, a | b};
      4'd5: r = (b == 8'd0) ? 16'hBAD0 : {8'h00, a / b};
      4'd6: r = {8'h00, a ^ b};
      4'd7: r = {a, b};
      default: r = {op, 4'h0, a ^ b};
    endcase
    return r;
  endfunction

  task automatic check(input int lane, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL lane%0d %s: got %0h, expected %0h", lane, name, act, exp);
    end
  endtask

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_lane
      localparam int S = (g == 0) ? 1 : 4;

      alu_driver #(.SETTLE_CYCLES(S)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid[g]),
        .cmd_ready  (cmd_ready[g]),
        .cmd_a      (cmd_a[g]),
        .cmd_b      (cmd_b[g]),
        .cmd_op     (cmd_op[g]),
        .a_in       (a_in[g]),
        .b_in       (b_in[g]),
        .command_in (command_in[g]),
        .oe         (oe[g]),
        .d_out      (d_out[g]),
        .res_valid  (res_valid[g]),
        .res_ready  (res_ready[g]),
        .res_data   (res_data[g]),
        .div_zero   (div_zero[g]),
        .op_count   (op_count[g])
      );

      // Stub ALU: junk on the bus whenever output enable is low.
      assign d_out[g] = oe[g] ? alu_f(a_in[g], b_in[g], command_in[g]) : 16'hDEAD;

      // Reference model: edge number of the accept decides every output window.
      int          m_n    = 0;
      int          m_acc  = 0;
      int          m_rise = 0;
      bit          m_busy = 1'b0;
      bit          m_dz   = 1'b0;
      logic [3:0]  m_op   = 4'd0;
      logic [7:0]  m_a    = 8'd0;
      logic [7:0]  m_b    = 8'd0;
      logic [15:0] m_res  = 16'd0;
      logic [7:0]  m_cnt  = 8'd0;

      initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          m_busy = 1'b0;
          m_a    = 8'd0;
          m_b    = 8'd0;
          m_cnt  = 8'd0;
        end else begin
          m_n++;
          if (m_busy) begin
            if (m_n > m_rise && res_ready[g]) begin
              m_busy = 1'b0;
              m_cnt  = m_cnt + 8'd1;
            end
          end else if (cmd_valid[g]) begin
            m_busy = 1'b1;
            m_acc  = m_n;
            m_a    = cmd_a[g];
            m_b    = cmd_b[g];
            m_op   = cmd_op[g];
            m_dz   = (m_op == DIVOP) && (m_b == 8'd0);
            m_res  = m_dz ? 16'hFFFF : alu_f(m_a, m_b, m_op);
            m_rise = m_dz ? m_acc : m_acc + S + 1;
          end
        end
      end

      initial forever begin
        bit exp_valid;
        bit exp_oe;
        @(negedge clk);
        exp_valid = m_busy && (m_n >= m_rise);
        exp_oe    = m_busy && !m_dz && (m_n >= m_acc + 1) && (m_n <= m_acc + S);
        check(g, "cmd_ready", 32'(cmd_ready[g]), 32'(!m_busy));
        check(g, "res_valid", 32'(res_valid[g]), 32'(exp_valid));
        check(g, "oe", 32'(oe[g]), 32'(exp_oe));
        check(g, "command_in", 32'(command_in[g]), 32'(exp_oe ? m_op : PARK));
        check(g, "a_in", 32'(a_in[g]), 32'(m_a));
        check(g, "b_in", 32'(b_in[g]), 32'(m_b));
        check(g, "op_count", 32'(op_count[g]), 32'(m_cnt));
        if (exp_valid) begin
          check(g, "res_data", 32'(res_data[g]), 32'(m_res));
          check(g, "div_zero", 32'(div_zero[g]), 32'(m_dz));
        end
      end
    end
  endgenerate

  // One operation: wait for ready, hand it over, wait for the result, then keep
  // res_ready low for 'hold' cycles (offering a second command meanwhile).
  task automatic do_op(input int i, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] op, input int hold,
                       output logic [15:0] data, output logic dz,
                       output int lat, output int oe_n);
    int guard;
    guard = 0;
    lat   = 0;
    oe_n  = 0;
    data  = 16'd0;
    dz    = 1'b0;
    while (!cmd_ready[i] && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!cmd_ready[i]) begin
      check(i, "cmd_ready wait expired", 32'd0, 32'd1);
      return;
    end
    cmd_valid[i] = 1'b1;
    cmd_a[i]     = a;
    cmd_b[i]     = b;
    cmd_op[i]    = op;
    @(posedge clk); #1;
    cmd_valid[i] = 1'b0;
    while (!res_valid[i] && lat < 40) begin
      if (oe[i]) oe_n++;
      @(posedge clk); #1;
      lat++;
    end
    if (!res_valid[i]) begin
      check(i, "res_valid wait expired", 32'd0, 32'd1);
      return;
    end
    data = res_data[i];
    dz   = div_zero[i];
    for (int k = 0; k < hold; k++) begin
      cmd_valid[i] = 1'b1;
      cmd_a[i]     = a ^ 8'h5A;
      cmd_b[i]     = b ^ 8'hA5;
      cmd_op[i]    = op ^ 4'h3;
      @(posedge clk); #1;
    end
    cmd_valid[i] = 1'b0;
    res_ready[i] = 1'b1;
    @(posedge clk); #1;
    res_ready[i] = 1'b0;
  endtask

  task automatic rand_op(input int i);
    logic [15:0] d;
    logic        z;
    int          l;
    int          o;
    logic [3:0]  op;
    logic [7:0]  b;
    op = 4'($urandom_range(0, 15));
    b  = 8'($urandom_range(0, 255));
    if (op == DIVOP && $urandom_range(0, 1) == 0) b = 8'd0;
    do_op(i, 8'($urandom_range(0, 255)), b, op, $urandom_range(0, 2), d, z, l, o);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    logic        z;
    int          lat;
    int          oe_n;

    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0;
      res_ready[i] = 1'b0;
      cmd_a[i]     = 8'd0;
      cmd_b[i]     = 8'd0;
      cmd_op[i]    = 4'd0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check(0, "reset a_in", 32'(a_in[0]), 32'h0);
    check(0, "reset b_in", 32'(b_in[0]), 32'h0);
    check(0, "reset res_data", 32'(res_data[0]), 32'h0);
    check(0, "reset div_zero", 32'(div_zero[0]), 32'h0);
    check(0, "reset command_in", 32'(command_in[0]), 32'hF);
    check(0, "reset oe", 32'(oe[0]), 32'h0);
    check(0, "reset res_valid", 32'(res_valid[0]), 32'h0);
    check(0, "reset op_count", 32'(op_count[0]), 32'h0);
    check(0, "reset cmd_ready", 32'(cmd_ready[0]), 32'h1);

    // ADD with res_ready already high.
    res_ready[0] = 1'b1;
    do_op(0, 8'hF0, 8'h20, 4'd0, 0, d, z, lat, oe_n);
    check(0, "add res_data", 32'(d), 32'h0110);
    check(0, "add div_zero", 32'(z), 32'h0);
    check(0, "add latency", 32'(lat), 32'd2);
    check(0, "add oe cycles", 32'(oe_n), 32'd1);
    check(0, "add op_count", 32'(op_count[0]), 32'd1);

    // Divide by zero is answered without touching the ALU.
    do_op(0, 8'h64, 8'h00, 4'd5, 0, d, z, lat, oe_n);
    check(0, "div0 res_data", 32'(d), 32'hFFFF);
    check(0, "div0 div_zero", 32'(z), 32'h1);
    check(0, "div0 latency", 32'(lat), 32'd0);
    check(0, "div0 oe cycles", 32'(oe_n), 32'd0);
    check(0, "div0 op_count", 32'(op_count[0]), 32'd2);

    // MUL held for 5 cycles; the extra command offered meanwhile must be ignored.
    do_op(0, 8'h0F, 8'h0F, 4'd2, 5, d, z, lat, oe_n);
    check(0, "mul res_data", 32'(d), 32'h00E1);
    check(0, "mul op_count", 32'(op_count[0]), 32'd3);
    check(0, "mul a_in kept", 32'(a_in[0]), 32'h0F);

    // Back-to-back SUBs.
    do_op(0, 8'd5, 8'd3, 4'd1, 0, d, z, lat, oe_n);
    check(0, "sub1 res_data", 32'(d), 32'h0002);
    check(0, "sub1 parked", 32'(command_in[0]), 32'hF);
    do_op(0, 8'd9, 8'd4, 4'd1, 0, d, z, lat, oe_n);
    check(0, "sub2 res_data", 32'(d), 32'h0005);

    for (int k = 0; k < 100; k++) rand_op(0);

    // Longer settle time.
    do_op(1, 8'h12, 8'h34, 4'd0, 0, d, z, lat, oe_n);
    check(1, "s4 add res_data", 32'(d), 32'h0046);
    check(1, "s4 add latency", 32'(lat), 32'd5);
    check(1, "s4 add oe cycles", 32'(oe_n), 32'd4);
    check(1, "s4 add op_count", 32'(op_count[1]), 32'd1);

    // Reset pulsed while an operation is in ISSUE.
    cmd_valid[1] = 1'b1;
    cmd_a[1]     = 8'h01;
    cmd_b[1]     = 8'h02;
    cmd_op[1]    = 4'd0;
    @(posedge clk); #1;
    cmd_valid[1] = 1'b0;
    @(posedge clk); #1;
    check(1, "issue oe", 32'(oe[1]), 32'h1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check(1, "async rst oe", 32'(oe[1]), 32'h0);
    check(1, "async rst res_valid", 32'(res_valid[1]), 32'h0);
    check(1, "async rst op_count", 32'(op_count[1]), 32'h0);
    check(1, "async rst command_in", 32'(command_in[1]), 32'hF);
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_op(1, 8'hA5, 8'h3C, 4'd6, 0, d, z, lat, oe_n);
    check(1, "post-reset xor res_data", 32'(d), 32'h0099);
    check(1, "post-reset latency", 32'(lat), 32'd5);
    check(1, "post-reset op_count", 32'(op_count[1]), 32'd1);

    for (int k = 0; k < 254; k++) rand_op(1);
    check(1, "op_count at 255", 32'(op_count[1]), 32'd255);
    rand_op(1);
    check(1, "op_count wrap", 32'(op_count[1]), 32'd0);

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
